instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Consumer side of the program-counter register. Accepts one PC value at a time, reads the
//  instruction word from instruction memory over a req/ack handshake, and queues {pc, insn}
//  pairs in a small FIFO for decode. Flush support covers branch/jump redirects.
//  Sits between the PC register and the IF/ID pipeline register.
// PARAMETERS
//  DEPTH_LOG2  1             FIFO depth = 2**DEPTH_LOG2 entries (legal range 1..4)
//  NOP_INSN    32'h00000013  instruction word substituted for misaligned fetches
// PORTS
//  clk_i         in   1   clock; all state updates on rising edge
//  rst_i         in   1   reset, synchronous, active-high
//  pc_i          in   32  PC value from the PC register
//  pc_valid_i    in   1   pc_i is valid this cycle
//  pc_ready_o    out  1   unit accepts pc_i this cycle (transfer = pc_valid_i & pc_ready_o)
//  imem_req_o    out  1   instruction memory read request, held until imem_ack_i
//  imem_addr_o   out  32  word-aligned read address, stable while imem_req_o=1
//  imem_ack_i    in   1   imem_data_i valid; completes the request
//  imem_data_i   in   32  instruction word
//  flush_i       in   1   discard queued entries and any in-flight response
//  inst_valid_o  out  1   FIFO head valid
//  inst_ready_i  in   1   decode takes head (pop = inst_valid_o & inst_ready_i)
//  inst_o        out  32  instruction at FIFO head
//  inst_pc_o     out  32  PC of instruction at FIFO head
//  inst_err_o    out  1   head entry came from a misaligned PC (pc[1:0]!=0)
// BEHAVIOUR
//  - Reset (rst_i=1 at an edge): state=IDLE, FIFO empty, imem_req_o=0, imem_addr_o=0,
//    inst_valid_o=0, inst_o=0, inst_pc_o=0, inst_err_o=0. Reset overrides flush and handshakes;
//    any in-flight imem transaction is abandoned (the memory is reset with the core).
//  - FSM: IDLE, REQ, DRAIN.
//      IDLE : pc_ready_o = (count < 2**DEPTH_LOG2) & ~flush_i.
//             Transfer with pc_i[1:0]==0  -> latch addr/pc, imem_req_o=1 next cycle, go REQ.
//             Transfer with pc_i[1:0]!=0  -> no memory access; push {pc_i, NOP_INSN, err=1};
//             stay IDLE.
//      REQ  : imem_req_o=1; pc_ready_o=0. imem_ack_i & ~flush_i -> push {pc, imem_data_i, err=0},
//             imem_req_o=0, go IDLE. flush_i & ~imem_ack_i -> go DRAIN (req stays 1).
//             flush_i & imem_ack_i -> data dropped, go IDLE.
//      DRAIN: imem_req_o=1; pc_ready_o=0. imem_ack_i -> drop data, req=0, go IDLE.
//  - At most one outstanding imem request. imem_ack_i outside REQ/DRAIN is ignored.
//  - Latency: PC accepted at edge N -> imem_req_o high in cycle N+1; ack in cycle M ->
//    inst_valid_o high in cycle M+1 (registered FIFO). Misaligned PC: inst_valid_o in N+1.
//  - FIFO: count width DEPTH_LOG2+1; pointers wrap modulo 2**DEPTH_LOG2. Push and pop in the same
//    cycle leave count unchanged and are legal at any occupancy, including full. Pop on empty
//    is impossible (gated by inst_valid_o). Push when full cannot occur because acceptance
//    requires count < depth while no request is outstanding.
//  - flush_i: next cycle count=0 and inst_valid_o=0; a same-cycle push or pop is discarded.
//    Flush has priority over pc_valid_i (pc_ready_o=0 during flush).
//  - inst_o/inst_pc_o/inst_err_o are stable while inst_valid_o=1 and no pop or flush occurs.
// STRUCTURE
//  - fetch_pkg: FSM state enum (IDLE/REQ/DRAIN), fetch entry struct {pc[31:0], insn[31:0], err},
//    default NOP constant.
//  - One sub-module: fetch_fifo (synchronous FIFO, parameterised by DEPTH_LOG2 and entry width,
//    with push/pop/clear and full/empty/count outputs). FSM and request logic live in
//    instr_fetch_unit.
// TESTING
//  1. Reset then PC=0x0000_0040 valid, ack after 2 cycles with 0x0020_8233 -> imem_addr_o=0x40,
//     req high 2 cycles; inst_o=0x0020_8233, inst_pc_o=0x40, err=0, valid one cycle after ack.
//  2. DEPTH_LOG2=1, inst_ready_i=0, three PCs 0x0,0x4,0x8 offered -> two accepted, pc_ready_o=0
//     with count=2; one pop -> 0x8 accepted next cycle.
//  3. PC=0x0000_0042 -> no imem_req_o; entry insn=0x00000013, pc=0x42, inst_err_o=1.
//  4. flush_i while in REQ, ack 3 cycles later -> DRAIN, ack data dropped, FIFO empty,
//     pc_ready_o returns the cycle after the ack.
//  5. FIFO full, simultaneous pop and ack of prior request impossible; instead pop+push at
//     count=1 -> count stays 1, order preserved (0x10 then 0x14).
//  6. rst_i asserted in REQ with FIFO holding 1 entry -> next cycle all outputs at reset values;
//     stale ack ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states, queued entry layout, default NOP.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        err;
    } fetch_entry_t;

    localparam logic [31:0] FETCH_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with registered storage; clear drops contents and wins over push/pop.
module fetch_fifo #(
    parameter int DEPTH_LOG2 = 1,
    parameter int W          = 65
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  push_i,
    input  logic [W-1:0]          push_dat_i,
    input  logic                  pop_i,
    output logic [W-1:0]          head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [W-1:0]          r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_push;
    logic                  w_pop;

    assign full_o  = (r_count == DEPTH_CNT);
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign head_o  = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so push at full is fine when paired with a pop.
    assign w_pop  = pop_i & ~empty_o;
    assign w_push = push_i & (~full_o | w_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clr_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_dat_i;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push & ~w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop & ~w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Takes one PC at a time, fetches its word over req/ack and queues {pc, insn, err} for decode.
// Misaligned PCs bypass memory and queue a NOP flagged as an error; flush drops queue and response.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 1,
    parameter logic [31:0] NOP_INSN   = FETCH_NOP
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic        pc_valid_i,
    output logic        pc_ready_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        flush_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_err_o
);

    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);

    fetch_state_t        r_state;
    logic [31:0]         r_addr;
    logic [31:0]         r_pc;

    logic                w_xfer;
    logic                w_aligned;
    logic                w_push;
    fetch_entry_t        w_push_ent;
    fetch_entry_t        w_head;
    logic                w_full;
    logic                w_empty;
    logic [DEPTH_LOG2:0] w_count;

    assign w_aligned    = (pc_i[1:0] == 2'b00);
    assign pc_ready_o   = (r_state == ST_IDLE) & (w_count < DEPTH_CNT) & ~flush_i;
    assign w_xfer       = pc_valid_i & pc_ready_o;
    assign imem_req_o   = (r_state != ST_IDLE);
    assign imem_addr_o  = r_addr;
    assign inst_valid_o = ~w_empty;
    assign inst_o       = w_head.insn;
    assign inst_pc_o    = w_head.pc;
    assign inst_err_o   = w_head.err;

    always_comb begin
        w_push     = 1'b0;
        w_push_ent = '0;
        if (r_state == ST_IDLE && w_xfer && !w_aligned) begin
            w_push     = 1'b1;
            w_push_ent = '{pc: pc_i, insn: NOP_INSN, err: 1'b1};
        end else if (r_state == ST_REQ && imem_ack_i && !flush_i) begin
            w_push     = 1'b1;
            w_push_ent = '{pc: r_pc, insn: imem_data_i, err: 1'b0};
        end
    end

    // A flushed request must still see its ack before a new one may issue (DRAIN).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_pc    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer && w_aligned) begin
                        r_addr  <= pc_i;
                        r_pc    <= pc_i;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (imem_ack_i) begin
                        r_state <= ST_IDLE;
                    end else if (flush_i) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ack_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .W          ($bits(fetch_entry_t))
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (flush_i),
        .push_i     (w_push),
        .push_dat_i (w_push_ent),
        .pop_i      (inst_valid_o & inst_ready_i),
        .head_o     (w_head),
        .full_o     (w_full),
        .empty_o    (w_empty),
        .count_o    (w_count)
    );

    no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_push && w_full && !(inst_valid_o && inst_ready_i) && !flush_i));

endmodule
